fifo_param: RTL and testbench

Parametrised synchronous FIFO for the transaction-layer datapath. It replaces fixed 10-bit/8-entry buffering with configurable data width and depth, and adds:
- programmable almost-full/almost-empty thresholds, latched during reset;
- occupancy count output;
- registered read data with a valid strobe;
- sticky overflow/underflow error flags.

It sits between the TLP producers and the per-class arbitration logic.

---
 rtl/fifo_param.sv | 107 ++++++++++
 tb/tb_fifo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// reset-latched almost-full/almost-empty thresholds and sticky error flags.
module fifo_param #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic [AW:0]       umbral_superior,
   input  logic [AW:0]       umbral_inferior,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow_err,
   output logic              underflow_err
);

   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [CW-1:0]     sup_q, inf_q;
   logic              full_c, empty_c, wr_ok, rd_ok;

   // Accept/reject decisions and next-state for pointers, count, read data and errors
   always_comb begin
      full_c     = (count_q == CW'(DEPTH));
      empty_c    = (count_q == '0);
      wr_ok      = push && (!full_c || pop);
      rd_ok      = pop && !empty_c;

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      count_d    = count_q + CW'(wr_ok) - CW'(rd_ok);

      if (wr_ok) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
         data_out_d = mem_q[rd_ptr_q];
         rd_ptr_d   = rd_ptr_q + AW'(1);
         valid_d    = 1'b1;
      end
      if (push && full_c && !pop) ovf_d = 1'b1;
      if (pop && empty_c)         unf_d = 1'b1;
   end

   // Storage is never cleared; writes are suppressed while reset is high
   always_ff @(posedge clk) begin
      if (!reset) mem_q <= mem_d;
   end

   // Control state with synchronous reset; thresholds latch only during reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         sup_q      <= umbral_superior;
         inf_q      <= umbral_inferior;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign data_out      = data_out_q;
   assign valid_out     = valid_q;
   assign count         = count_q;
   assign full          = full_c;
   assign empty         = empty_c;
   assign almost_full   = (count_q >= sup_q);
   assign almost_empty  = (count_q <= inf_q);
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: queue-based reference model, directed
// scenarios followed by randomized push/pop traffic with occasional resets.
module tb_fifo_param;

   localparam int unsigned DATA_W = 10;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned AW     = 3;

   logic              clk = 1'b0;
   logic              reset, push, pop;
   logic [DATA_W-1:0] data_in;
   logic [AW:0]       umbral_superior, umbral_inferior;
   logic [DATA_W-1:0] data_out;
   logic              valid_out, full, empty, almost_full, almost_empty;
   logic              overflow_err, underflow_err;
   logic [AW:0]       count;

   fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .push           (push),
      .pop            (pop),
      .data_in        (data_in),
      .umbral_superior(umbral_superior),
      .umbral_inferior(umbral_inferior),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .count          (count),
      .full           (full),
      .empty          (empty),
      .almost_full    (almost_full),
      .almost_empty   (almost_empty),
      .overflow_err   (overflow_err),
      .underflow_err  (underflow_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a queue, plus expected popped words for the monitor
   int mq[$];
   int sb[$];
   int m_sup, m_inf, m_dout;
   bit m_ovf, m_unf;
   bit done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, " count"}, 32'(count), mq.size());
      chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
      chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(mq.size() >= m_sup));
      chk({tag, " almost_empty"}, 32'(almost_empty), 32'(mq.size() <= m_inf));
      chk({tag, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
      chk({tag, " underflow_err"}, 32'(underflow_err), 32'(m_unf));
      chk({tag, " data_out"}, 32'(data_out), m_dout);
   endtask

   task automatic do_reset(input int cycles, input int sup, input int inf, input bit p);
      reset           = 1'b1;
      push            = p;
      pop             = 1'b0;
      data_in         = DATA_W'($urandom_range(0, 1023));
      umbral_superior = (AW+1)'(sup);
      umbral_inferior = (AW+1)'(inf);
      repeat (cycles) @(posedge clk);
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = 0;
      m_sup  = sup;
      m_inf  = inf;
      #1;
      reset = 1'b0;
      push  = 1'b0;
      check_state("reset");
      chk("reset valid_out", 32'(valid_out), 0);
   endtask

   task automatic step(input bit p, input bit q, input int d);
      bit f, e;
      push    = p;
      pop     = q;
      data_in = DATA_W'(d);
      @(posedge clk);
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (p && f && !q) m_ovf = 1'b1;
      if (q && e)       m_unf = 1'b1;
      if (q && !e) begin
         m_dout = mq.pop_front();
         sb.push_back(m_dout);
      end
      if (p && (!f || q)) mq.push_back(d);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      check_state("step");
   endtask

   // Monitor: every valid_out must match the next expected popped word
   always @(negedge clk) begin
      if (!done) begin
         bit exp_v;
         int exp_d;
         exp_v = (sb.size() != 0);
         chk("sb valid_out", 32'(valid_out), 32'(exp_v));
         if (exp_v) begin
            exp_d = sb.pop_front();
            if (valid_out) chk("sb data_out", 32'(data_out), exp_d);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int bias;
      reset           = 1'b1;
      push            = 1'b0;
      pop             = 1'b0;
      data_in         = '0;
      umbral_superior = 4'd6;
      umbral_inferior = 4'd1;
      @(negedge clk);
      do_reset(2, 6, 1, 1'b0);

      // Fill past full, then drain past empty
      for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, i);
      repeat (11) step(1'b0, 1'b1, 0);

      // Simultaneous push/pop from empty, then from full with wrapped pointers
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 22 + i);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 30 + i);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 40 + i);
      repeat (8) step(1'b0, 1'b1, 0);

      // Mid-operation reset with push held and new thresholds
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 60 + i);
      do_reset(1, 4, 2, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 70 + i);
      repeat (5) step(1'b0, 1'b1, 0);

      // Alternating bursts across pointer wrap
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 100 + 10 * b + i);
         for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0);
      end

      // Random traffic with varying push bias and occasional resets
      bias = 50;
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 0) bias = $urandom_range(20, 80);
         if ($urandom_range(0, 99) == 0)
            do_reset($urandom_range(1, 2), $urandom_range(0, 15), $urandom_range(0, 15),
                     1'($urandom_range(0, 1)));
         else
            step(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < 50),
                 $urandom_range(0, 1023));
      end

      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      done = 1'b1;
      chk("scoreboard drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
